// File: rtl/intersect_stim_gen_pkg.sv
// Shared types and constants for the intersect stimulus generator.
//   state_e   : controller states (IDLE, RUN, DONE)
//   LEN_W_DEF : default width of the length/index fields
//   DROP_NONE : drop_idx value meaning "never drop transport"
package intersect_stim_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int DROP_NONE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/intersect_stim_gen_if.sv
// Driving interface between the stimulus generator and its consumer.
//   start/bus_len/train_len/drop_idx : window request (into the generator)
//   transport/bus/train               : stimulus pulses (out of the generator)
//   busy/done/match_exp/len_err       : status and expected checker verdict
// master = generator side, slave = consumer (bench/checker) side.
interface intersect_stim_gen_if #(
  parameter int LEN_W = intersect_stim_pkg::LEN_W_DEF
);
  logic             start;
  logic [LEN_W-1:0] bus_len;
  logic [LEN_W-1:0] train_len;
  logic [LEN_W-1:0] drop_idx;
  logic             transport;
  logic             bus;
  logic             train;
  logic             busy;
  logic             done;
  logic             match_exp;
  logic             len_err;

  modport master (
    input  start, bus_len, train_len, drop_idx,
    output transport, bus, train, busy, done, match_exp, len_err
  );

  modport slave (
    output start, bus_len, train_len, drop_idx,
    input  transport, bus, train, busy, done, match_exp, len_err
  );
endinterface

// File: rtl/intersect_stim_gen_win_cnt.sv
// stim_win_cnt: loadable up-counter tracking the current window cycle.
//   clk      : clock
//   clr_n    : synchronous active-low clear (cnt -> 0)
//   load     : load load_val (takes priority over en)
//   en       : increment by one
//   load_val : value loaded on load
//   win_len  : terminal count
//   cnt      : current count
//   tc       : cnt == win_len
module stim_win_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] win_len,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (!clr_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == win_len);

endmodule

// File: rtl/intersect_stim_gen.sv
// intersect_stim_gen: drives one window of bus/train pulses with transport
// held high (optionally dropped on one cycle) per accepted start, then
// reports the verdict a "transport throughout (bus intersect train)" checker
// must reach.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   sif   : generator side of intersect_stim_gen_if (request in, stimulus
//           and status out)
// All stimulus/status outputs except busy are registered; busy follows the
// controller state directly.
module intersect_stim_gen
  import intersect_stim_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  intersect_stim_gen_if.master  sif
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] bus_len_q, train_len_q, drop_q, win_len_q;
  logic [LEN_W-1:0] cnt;
  logic             tc;
  logic             req_ok, accept, reject;

  // next-cycle values of the registered outputs
  logic transport_d, bus_d, train_d, done_d, match_d, len_err_d;

  assign req_ok = (sif.bus_len != '0) && (sif.train_len != '0);
  assign accept = (state_q == IDLE) && sif.start && req_ok;
  assign reject = (state_q == IDLE) && sif.start && !req_ok;

  // Request capture; window length is the longer of the two pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_len_q   <= '0;
      train_len_q <= '0;
      drop_q      <= '0;
      win_len_q   <= '0;
    end else if (accept) begin
      bus_len_q   <= sif.bus_len;
      train_len_q <= sif.train_len;
      drop_q      <= sif.drop_idx;
      win_len_q   <= (sif.bus_len > sif.train_len) ? sif.bus_len : sif.train_len;
    end
  end

  // Counter holds at win_len once reached, so it never wraps.
  stim_win_cnt #(.W(LEN_W)) u_cnt (
    .clk      (clk),
    .clr_n    (rst_n),
    .load     (accept),
    .en       ((state_q == RUN) && !tc),
    .load_val (LEN_W'(1)),
    .win_len  (win_len_q),
    .cnt      (cnt),
    .tc       (tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (tc)     state_d = DONE;
      DONE:                state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Output logic: the value computed for the current state is what the
  // consumer sees one edge later.
  always_comb begin
    transport_d = 1'b0;
    bus_d       = 1'b0;
    train_d     = 1'b0;
    done_d      = 1'b0;
    match_d     = 1'b0;
    len_err_d   = 1'b0;
    case (state_q)
      IDLE: len_err_d = reject;
      RUN: begin
        bus_d       = (cnt <= bus_len_q);
        train_d     = (cnt <= train_len_q);
        // cnt starts at 1, so drop_idx == 0 never matches
        transport_d = (cnt != drop_q);
      end
      DONE: begin
        done_d  = 1'b1;
        // a drop index past the window never lands inside it
        match_d = (bus_len_q == train_len_q) &&
                  ((drop_q == LEN_W'(DROP_NONE)) || (drop_q > win_len_q));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sif.transport <= 1'b0;
      sif.bus       <= 1'b0;
      sif.train     <= 1'b0;
      sif.done      <= 1'b0;
      sif.match_exp <= 1'b0;
      sif.len_err   <= 1'b0;
    end else begin
      sif.transport <= transport_d;
      sif.bus       <= bus_d;
      sif.train     <= train_d;
      sif.done      <= done_d;
      sif.match_exp <= match_d;
      sif.len_err   <= len_err_d;
    end
  end

  assign sif.busy = (state_q != IDLE);

endmodule

// File: tb/tb_intersect_stim_gen.sv
module tb_intersect_stim_gen;
  localparam int LW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  intersect_stim_gen_if #(.LEN_W(LW)) sif();

  intersect_stim_gen #(.LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // advance one edge and sample away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int bl, input int tl, input int di);
    sif.start     = s;
    sif.bus_len   = bl[LW-1:0];
    sif.train_len = tl[LW-1:0];
    sif.drop_idx  = di[LW-1:0];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".transport"}, sif.transport, 1'b0);
    chk({tag, ".bus"},       sif.bus,       1'b0);
    chk({tag, ".train"},     sif.train,     1'b0);
    chk({tag, ".busy"},      sif.busy,      1'b0);
    chk({tag, ".done"},      sif.done,      1'b0);
    chk({tag, ".match"},     sif.match_exp, 1'b0);
    chk({tag, ".len_err"},   sif.len_err,   1'b0);
  endtask

  // One window request. poke_at: re-assert start (different lengths) on the
  // edge of that window cycle. abort_at: assert reset on that window cycle.
  task automatic run_window(input int bl, input int tl, input int di,
                            input int poke_at, input int abort_at);
    int    w;
    bit    mexp;
    string t;
    logic  eb[$], et[$], ep[$];
    w    = (bl > tl) ? bl : tl;
    mexp = (bl == tl) && (di == 0 || di > w);
    for (int n = 1; n <= w; n++) begin
      eb.push_back(n <= bl);
      et.push_back(n <= tl);
      ep.push_back(n != di);
    end
    t = $sformatf("w%0d_%0d_%0d", bl, tl, di);

    drive(1'b1, bl, tl, di);
    tick();
    drive(1'b0, 0, 0, 0);
    chk({t, ".acc.busy"}, sif.busy, 1'b1);
    chk({t, ".acc.bus"},  sif.bus,  1'b0);
    chk({t, ".acc.err"},  sif.len_err, 1'b0);

    for (int n = 1; n <= w; n++) begin
      if (n == poke_at) drive(1'b1, 1, 1, 0);
      if (n == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, 0, 0, 0);
        chk_quiet({t, ".abort"});
        for (int i = 0; i < w + 2; i++) begin
          tick();
          chk({t, ".abort.nodone"}, sif.done, 1'b0);
          chk({t, ".abort.busy"},   sif.busy, 1'b0);
        end
        return;
      end
      tick();
      drive(1'b0, 0, 0, 0);
      chk($sformatf("%s.bus@%0d", t, n),       sif.bus,       eb[n-1]);
      chk($sformatf("%s.train@%0d", t, n),     sif.train,     et[n-1]);
      chk($sformatf("%s.transport@%0d", t, n), sif.transport, ep[n-1]);
      chk($sformatf("%s.done@%0d", t, n),      sif.done,      1'b0);
      chk($sformatf("%s.match@%0d", t, n),     sif.match_exp, 1'b0);
      chk($sformatf("%s.busy@%0d", t, n),      sif.busy,      1'b1);
      chk($sformatf("%s.err@%0d", t, n),       sif.len_err,   1'b0);
    end

    tick();
    chk({t, ".done"},      sif.done,      1'b1);
    chk({t, ".match"},     sif.match_exp, mexp);
    chk({t, ".d.bus"},     sif.bus,       1'b0);
    chk({t, ".d.train"},   sif.train,     1'b0);
    chk({t, ".d.transp"},  sif.transport, 1'b0);
    chk({t, ".d.busy"},    sif.busy,      1'b0);
  endtask

  task automatic reject(input int bl, input int tl);
    string t;
    t = $sformatf("rej%0d_%0d", bl, tl);
    drive(1'b1, bl, tl, 0);
    tick();
    drive(1'b0, 0, 0, 0);
    chk({t, ".len_err"}, sif.len_err, 1'b1);
    chk({t, ".busy"},    sif.busy,    1'b0);
    chk({t, ".bus"},     sif.bus,     1'b0);
    tick();
    chk({t, ".len_err2"}, sif.len_err, 1'b0);
    chk({t, ".busy2"},    sif.busy,    1'b0);
  endtask

  initial begin
    int bl, tl, di, gap;

    // start held during reset must be discarded
    rst_n = 1'b0;
    drive(1'b1, 3, 3, 0);
    repeat (3) begin
      tick();
      chk_quiet("rst_start");
    end
    drive(1'b0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      chk_quiet("idle");
    end

    run_window(3, 3, 0, 0, 0);
    run_window(2, 4, 0, 0, 0);
    run_window(4, 4, 3, 0, 0);
    run_window(4, 4, 7, 0, 0);
    run_window(1, 1, 0, 0, 0);
    run_window(1, 1, 1, 0, 0);
    run_window(15, 15, 15, 0, 0);
    run_window(6, 2, 6, 0, 0);

    reject(0, 2);
    reject(3, 0);

    run_window(3, 5, 0, 2, 0);
    run_window(5, 5, 0, 0, 3);
    run_window(2, 2, 0, 0, 0);

    for (int k = 0; k < 25; k++) begin
      bl  = int'($urandom_range(1, 15));
      tl  = int'($urandom_range(1, 15));
      if ($urandom_range(0, 2) == 0) tl = bl;
      di  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      run_window(bl, tl, di, 0, 0);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        tick();
        chk_quiet("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
